// File: rtl/beep.sv
// Buzzer driver: level-dependent tone pitch gated by a level-dependent on/off cadence.
// Define BEEP_OUT_ACTIVE_LOW_EN to invert beep_out for active-low buzzer hardware.
//
// gate phase | meaning
// GATE_ON    | tone passes to beep_out
// GATE_OFF   | output silent, tone counter keeps running
module beep #(
  parameter int TONE_HALF_BASE = 12500,
  parameter int CADENCE_CYCLES = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       beep_en,
  input  logic [2:0] state,
  output logic       beep_out
);

  localparam int HALF_MAX = TONE_HALF_BASE * 8;
  localparam int TW = ($clog2(HALF_MAX + 1) > 20) ? $clog2(HALF_MAX + 1) : 20;
  localparam int GW = $clog2(CADENCE_CYCLES + 1);

`ifdef BEEP_OUT_ACTIVE_LOW_EN
  localparam logic IDLE_LEVEL = 1'b1;
`else
  localparam logic IDLE_LEVEL = 1'b0;
`endif

  typedef enum logic {GATE_ON = 1'b0, GATE_OFF = 1'b1} gate_t;

  gate_t         gate_ph, gate_ph_nx;
  logic [TW-1:0] tone_cnt, tone_cnt_nx;
  logic [GW-1:0] gate_cnt, gate_cnt_nx;
  logic          tone_ph, tone_ph_nx;
  logic [2:0]    prev_state, prev_state_nx;
  logic          beep_nx;

  logic          active;
  logic [3:0]    half_mul;
  logic [TW-1:0] half;
  logic [GW-1:0] gate_len;

  assign active   = beep_en && (state != 3'd0);
  assign half_mul = 4'd8 - {1'b0, state};
  assign half     = TW'(TONE_HALF_BASE) * TW'(half_mul);

  always_comb begin
    gate_len = GW'(CADENCE_CYCLES);
    if (state >= 3'd4)
      gate_len = GW'(CADENCE_CYCLES / 2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_cnt   <= '0;
      tone_ph    <= 1'b0;
      gate_cnt   <= '0;
      gate_ph    <= GATE_ON;
      prev_state <= 3'd0;
      beep_out   <= IDLE_LEVEL;
    end else begin
      tone_cnt   <= tone_cnt_nx;
      tone_ph    <= tone_ph_nx;
      gate_cnt   <= gate_cnt_nx;
      gate_ph    <= gate_ph_nx;
      prev_state <= prev_state_nx;
      beep_out   <= beep_nx;
    end
  end

  // prev_state is forced to 0 while inactive, so the first active cycle is
  // detected by the same state-change compare that handles mid-tone restarts.
  always_comb begin
    tone_cnt_nx   = tone_cnt;
    tone_ph_nx    = tone_ph;
    gate_cnt_nx   = gate_cnt;
    gate_ph_nx    = gate_ph;
    prev_state_nx = prev_state;
    if (!active) begin
      tone_cnt_nx   = '0;
      tone_ph_nx    = 1'b0;
      gate_cnt_nx   = '0;
      gate_ph_nx    = GATE_ON;
      prev_state_nx = 3'd0;
    end else if (state != prev_state) begin
      tone_cnt_nx   = '0;
      tone_ph_nx    = 1'b1;
      gate_cnt_nx   = '0;
      gate_ph_nx    = GATE_ON;
      prev_state_nx = state;
    end else begin
      if (tone_cnt >= half - TW'(1)) begin
        tone_cnt_nx = '0;
        tone_ph_nx  = ~tone_ph;
      end else begin
        tone_cnt_nx = tone_cnt + TW'(1);
      end
      if (state == 3'd7) begin
        gate_cnt_nx = '0;
        gate_ph_nx  = GATE_ON;
      end else if (gate_cnt >= gate_len - GW'(1)) begin
        gate_cnt_nx = '0;
        gate_ph_nx  = (gate_ph == GATE_ON) ? GATE_OFF : GATE_ON;
      end else begin
        gate_cnt_nx = gate_cnt + GW'(1);
      end
    end
    beep_nx = (tone_ph_nx && (gate_ph_nx == GATE_ON) && active) ^ IDLE_LEVEL;
  end

endmodule

// File: tb/tb_beep.sv
// Randomized and directed bench for beep; expected output derived from elapsed
// cycles since the last (re)start of the pattern.
module tb_beep;

  localparam int TONE_HALF_BASE = 2;
  localparam int CADENCE_CYCLES = 20;

`ifdef BEEP_OUT_ACTIVE_LOW_EN
  localparam logic IDLE_LEVEL = 1'b1;
`else
  localparam logic IDLE_LEVEL = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       beep_en;
  logic [2:0] state;
  logic       beep_out;

  int n_checks = 0;
  int n_fail   = 0;

  int         m_n;
  bit         m_act;
  logic [2:0] m_st;

  beep #(
    .TONE_HALF_BASE(TONE_HALF_BASE),
    .CADENCE_CYCLES(CADENCE_CYCLES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .beep_en(beep_en),
    .state(state),
    .beep_out(beep_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Tone is high during even multiples of half since restart; gate is on
  // during even multiples of the cadence length (always on at level 7).
  function automatic logic model_edge(input logic en, input logic [2:0] st);
    int  half, len;
    bit  tone, gate;
    if (!en || st == 3'd0) begin
      m_act = 0;
      m_st  = 3'd0;
      return 1'b0;
    end
    if (!m_act || st != m_st) m_n = 0;
    else m_n++;
    m_act = 1;
    m_st  = st;
    half  = TONE_HALF_BASE * (8 - int'(st));
    len   = (st <= 3'd3) ? CADENCE_CYCLES : CADENCE_CYCLES / 2;
    tone  = ((m_n / half) % 2) == 0;
    gate  = (st == 3'd7) || (((m_n / len) % 2) == 0);
    return logic'(tone && gate);
  endfunction

  task automatic step(input string tag);
    logic exp;
    @(posedge clk);
    exp = model_edge(beep_en, state);
    #1;
    check(tag, beep_out, exp ^ IDLE_LEVEL);
  endtask

  task automatic run(input string tag, input logic en, input logic [2:0] st, input int cycles);
    beep_en = en;
    state   = st;
    for (int i = 0; i < cycles; i++) step(tag);
  endtask

  initial begin
    m_n = 0; m_act = 0; m_st = 3'd0;
    rst_n   = 1'b0;
    beep_en = 1'b1;
    state   = 3'd3;
    #3;
    check("reset_idle", beep_out, IDLE_LEVEL);
    #20;
    rst_n = 1'b1;
    run("first_after_reset", 1'b1, 3'd3, 7);

    // asynchronous reset mid-tone, released before the next edge
    #1 rst_n = 1'b0;
    #1 check("async_reset", beep_out, IDLE_LEVEL);
    m_act = 0; m_st = 3'd0;
    #1 rst_n = 1'b1;
    run("after_release", 1'b1, 3'd3, 5);

    run("lvl7_cont", 1'b1, 3'd7, 24);
    run("lvl1_slow", 1'b1, 3'd1, 90);
    run("lvl5_fast", 1'b1, 3'd5, 45);
    run("lvl0_silent", 1'b1, 3'd0, 50);
    run("en_low", 1'b0, 3'd3, 20);
    run("en_rise", 1'b1, 3'd3, 30);
    run("lvl4", 1'b1, 3'd4, 7);
    run("restart_4_to_6", 1'b1, 3'd6, 30);

    for (int seg = 0; seg < 60; seg++) begin
      logic       en;
      logic [2:0] st;
      en = ($urandom_range(0, 3) != 0);
      st = 3'($urandom_range(0, 7));
      run("random", en, st, $urandom_range(1, 60));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
